// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame controller.
//   - lcd_state_e  : controller state encoding
//   - entry_type_e : init-ROM entry type field {type[1:0]}
//   - OP_RAMWR     : memory-write command that opens every frame
//   - ROM geometry and a default init program
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT_FETCH = 3'd0,
        ST_INIT_SEND  = 3'd1,
        ST_INIT_DELAY = 3'd2,
        ST_IDLE       = 3'd3,
        ST_WR_CMD     = 3'd4,
        ST_PIX_HI     = 3'd5,
        ST_PIX_LO     = 3'd6
    } lcd_state_e;

    typedef enum logic [1:0] {
        ENT_CMD   = 2'b00,
        ENT_DATA  = 2'b01,
        ENT_DELAY = 2'b10,
        ENT_END   = 2'b11
    } entry_type_e;

    localparam logic [7:0] OP_RAMWR  = 8'h2C;

    localparam int ROM_AW    = 4;
    localparam int ROM_DEPTH = 16;
    localparam int ENTRY_W   = 10;

    // Entry 0 sits in the least-significant 10 bits.
    // Program: cmd 0x11, delay 2 ticks, cmd 0x29, end (rest padded with end).
    localparam logic [ROM_DEPTH*ENTRY_W-1:0] ROM_DEFAULT =
        {{12{10'h300}}, 10'h300, 10'h029, 10'h202, 10'h011};

    // Split a ROM word into its type field.
    function automatic entry_type_e entry_type(input logic [ENTRY_W-1:0] word);
        return entry_type_e'(word[9:8]);
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Init-sequence ROM: synchronous read, one-cycle latency.
// Contents are supplied as a packed hex parameter (entry 0 in the LSBs),
// each entry being {type[1:0], byte[7:0]}.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears the read register)
//   addr  : entry address
//   rdata : entry at the address presented on the previous rising edge
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] INIT_HEX = ROM_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ROM_AW-1:0]   addr,
    output logic [ENTRY_W-1:0]  rdata
);

    // Registered ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 10'd0;
        end else begin
            rdata <= INIT_HEX[int'(addr) * ENTRY_W +: ENTRY_W];
        end
    end

endmodule

// File: rtl/lcd_frame_ctrl.sv
// LCD frame controller: plays an init program from ROM to the PHY, then on
// each enabled frame-mark strobe streams one frame of RGB565 pixels as
// command 0x2C followed by hi/lo byte pairs.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   phy_data/rs/valid, phy_ready : byte stream to the PHY (valid/ready)
//   phy_fmark_stb   : tearing strobe, starts a frame when idle and enabled
//   px_data/valid, px_ready      : pixel input (valid/ready)
//   en              : frame refresh enable
//   init_done       : sticky, init program finished
//   frame_stb       : pulses on the cycle the last byte of a frame transfers
module lcd_frame_ctrl
    import lcd_pkg::*;
#(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int DELAY_UNIT = 1024,
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] INIT_HEX = ROM_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  phy_data,
    output logic        phy_rs,
    output logic        phy_valid,
    input  logic        phy_ready,
    input  logic        phy_fmark_stb,
    input  logic [15:0] px_data,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic        en,
    output logic        init_done,
    output logic        frame_stb
);

    localparam int NPIX = H_RES * V_RES;
    localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int DW   = 8 + $clog2(DELAY_UNIT + 1);
    localparam logic [PCW-1:0] LAST_PIX   = PCW'(NPIX - 1);
    localparam logic [DW-1:0]  DLY_UNIT_W = DW'(DELAY_UNIT);

    lcd_state_e        state_r, state_nx_s;
    logic [ROM_AW-1:0] addr_r, addr_nx_s;
    logic              fetch_ph_r, fetch_ph_nx_s;
    logic [DW-1:0]     dly_cnt_r, dly_cnt_nx_s;
    logic [PCW-1:0]    pix_cnt_r, pix_cnt_nx_s;
    logic [15:0]       px_lat_r, px_lat_nx_s;
    logic              px_full_r, px_full_nx_s;
    logic              out_lo_r, out_lo_nx_s;
    logic [7:0]        phy_data_r, phy_data_nx_s;
    logic              phy_rs_r, phy_rs_nx_s;
    logic              phy_valid_r, phy_valid_nx_s;
    logic              px_ready_r, px_ready_nx_s;
    logic              init_done_r, init_done_nx_s;

    logic [ENTRY_W-1:0] rom_q_s;
    entry_type_e        ent_s;
    logic               xfer_s;
    logic               px_fire_s;
    logic               slot_free_s;

    lcd_init_rom #(
        .INIT_HEX (INIT_HEX)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr_r),
        .rdata (rom_q_s)
    );

    assign ent_s       = entry_type(rom_q_s);
    assign xfer_s      = phy_valid_r & phy_ready;
    assign px_fire_s   = px_valid & px_ready_r;
    // The output byte register can take a new byte when empty or draining now.
    assign slot_free_s = ~phy_valid_r | xfer_s;

    // Next-state, next-output and datapath logic.
    always_comb begin
        state_nx_s     = state_r;
        addr_nx_s      = addr_r;
        fetch_ph_nx_s  = fetch_ph_r;
        dly_cnt_nx_s   = dly_cnt_r;
        px_lat_nx_s    = px_lat_r;
        px_full_nx_s   = px_full_r;
        out_lo_nx_s    = out_lo_r;
        phy_data_nx_s  = phy_data_r;
        phy_rs_nx_s    = phy_rs_r;
        phy_valid_nx_s = phy_valid_r;
        init_done_nx_s = init_done_r;

        // Count each transferred low byte; the count saturates on the last pixel.
        if (xfer_s && out_lo_r && (pix_cnt_r != LAST_PIX)) begin
            pix_cnt_nx_s = pix_cnt_r + PCW'(1);
        end else begin
            pix_cnt_nx_s = pix_cnt_r;
        end

        case (state_r)
            ST_INIT_FETCH: begin
                // Phase 0 presents the address, phase 1 sees the ROM word.
                if (!fetch_ph_r) begin
                    fetch_ph_nx_s = 1'b1;
                end else begin
                    fetch_ph_nx_s = 1'b0;
                    case (ent_s)
                        ENT_CMD, ENT_DATA: begin
                            phy_data_nx_s  = rom_q_s[7:0];
                            phy_rs_nx_s    = (ent_s == ENT_DATA);
                            phy_valid_nx_s = 1'b1;
                            state_nx_s     = ST_INIT_SEND;
                        end
                        ENT_DELAY: begin
                            dly_cnt_nx_s = DW'(rom_q_s[7:0]) * DLY_UNIT_W;
                            state_nx_s   = ST_INIT_DELAY;
                        end
                        ENT_END: begin
                            init_done_nx_s = 1'b1;
                            state_nx_s     = ST_IDLE;
                        end
                        default: begin
                            state_nx_s = ST_INIT_FETCH;
                        end
                    endcase
                end
            end

            ST_INIT_SEND: begin
                if (xfer_s) begin
                    phy_valid_nx_s = 1'b0;
                    addr_nx_s      = addr_r + ROM_AW'(1);
                    state_nx_s     = ST_INIT_FETCH;
                end else begin
                    state_nx_s = ST_INIT_SEND;
                end
            end

            ST_INIT_DELAY: begin
                // A count of 0 or 1 leaves after this single cycle.
                if (dly_cnt_r <= DW'(1)) begin
                    addr_nx_s  = addr_r + ROM_AW'(1);
                    state_nx_s = ST_INIT_FETCH;
                end else begin
                    dly_cnt_nx_s = dly_cnt_r - DW'(1);
                end
            end

            ST_IDLE: begin
                if (en && phy_fmark_stb) begin
                    phy_data_nx_s  = OP_RAMWR;
                    phy_rs_nx_s    = 1'b0;
                    phy_valid_nx_s = 1'b1;
                    out_lo_nx_s    = 1'b0;
                    state_nx_s     = ST_WR_CMD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_WR_CMD: begin
                if (xfer_s) begin
                    phy_valid_nx_s = 1'b0;
                    pix_cnt_nx_s   = '0;
                    state_nx_s     = ST_PIX_HI;
                end else begin
                    state_nx_s = ST_WR_CMD;
                end
            end

            ST_PIX_HI: begin
                // The previous low byte may still be on the PHY here; a pixel
                // accepted meanwhile waits in the latch.
                if (slot_free_s) begin
                    out_lo_nx_s = 1'b0;
                    if (px_full_r) begin
                        phy_data_nx_s  = px_lat_r[15:8];
                        phy_rs_nx_s    = 1'b1;
                        phy_valid_nx_s = 1'b1;
                        px_full_nx_s   = 1'b0;
                        state_nx_s     = ST_PIX_LO;
                    end else if (px_fire_s) begin
                        px_lat_nx_s    = px_data;
                        phy_data_nx_s  = px_data[15:8];
                        phy_rs_nx_s    = 1'b1;
                        phy_valid_nx_s = 1'b1;
                        state_nx_s     = ST_PIX_LO;
                    end else begin
                        phy_valid_nx_s = 1'b0;
                    end
                end else begin
                    if (px_fire_s) begin
                        px_lat_nx_s  = px_data;
                        px_full_nx_s = 1'b1;
                    end else begin
                        px_full_nx_s = px_full_r;
                    end
                end
            end

            ST_PIX_LO: begin
                // out_lo_r low: high byte on the PHY. High: last low byte of frame.
                if (!out_lo_r) begin
                    if (xfer_s) begin
                        phy_data_nx_s  = px_lat_r[7:0];
                        phy_rs_nx_s    = 1'b1;
                        phy_valid_nx_s = 1'b1;
                        out_lo_nx_s    = 1'b1;
                        if (pix_cnt_r != LAST_PIX) begin
                            state_nx_s = ST_PIX_HI;
                        end else begin
                            state_nx_s = ST_PIX_LO;
                        end
                    end else begin
                        state_nx_s = ST_PIX_LO;
                    end
                end else begin
                    if (xfer_s) begin
                        phy_valid_nx_s = 1'b0;
                        out_lo_nx_s    = 1'b0;
                        state_nx_s     = ST_IDLE;
                    end else begin
                        state_nx_s = ST_PIX_LO;
                    end
                end
            end

            default: begin
                state_nx_s     = ST_INIT_FETCH;
                addr_nx_s      = '0;
                fetch_ph_nx_s  = 1'b0;
                phy_valid_nx_s = 1'b0;
                out_lo_nx_s    = 1'b0;
            end
        endcase

        px_ready_nx_s = (state_nx_s == ST_PIX_HI) && !px_full_nx_s;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT_FETCH;
            addr_r      <= '0;
            fetch_ph_r  <= 1'b0;
            dly_cnt_r   <= '0;
            pix_cnt_r   <= '0;
            px_lat_r    <= 16'h0000;
            px_full_r   <= 1'b0;
            out_lo_r    <= 1'b0;
            phy_data_r  <= 8'h00;
            phy_rs_r    <= 1'b0;
            phy_valid_r <= 1'b0;
            px_ready_r  <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            addr_r      <= addr_nx_s;
            fetch_ph_r  <= fetch_ph_nx_s;
            dly_cnt_r   <= dly_cnt_nx_s;
            pix_cnt_r   <= pix_cnt_nx_s;
            px_lat_r    <= px_lat_nx_s;
            px_full_r   <= px_full_nx_s;
            out_lo_r    <= out_lo_nx_s;
            phy_data_r  <= phy_data_nx_s;
            phy_rs_r    <= phy_rs_nx_s;
            phy_valid_r <= phy_valid_nx_s;
            px_ready_r  <= px_ready_nx_s;
            init_done_r <= init_done_nx_s;
        end
    end

    assign phy_data  = phy_data_r;
    assign phy_rs    = phy_rs_r;
    assign phy_valid = phy_valid_r;
    assign px_ready  = px_ready_r;
    assign init_done = init_done_r;
    // Must coincide with the transfer itself, so it is decoded from registers
    // and phy_ready rather than registered.
    assign frame_stb = xfer_s & out_lo_r & (pix_cnt_r == LAST_PIX);

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Self-checking bench for lcd_frame_ctrl (2x2 frame, DELAY_UNIT=4, default ROM).
module tb_lcd_frame_ctrl;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  phy_data;
    logic        phy_rs;
    logic        phy_valid;
    logic        phy_ready;
    logic        phy_fmark_stb;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        en;
    logic        init_done;
    logic        frame_stb;

    exp_t        exp_q[$];
    logic [15:0] px_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int frames = 0;
    int pop_cnt = 0;
    int cyc = 0;
    int cyc_since = 0;
    int last_gap = 0;
    int first_px_cyc = 0;
    int stb_cyc = 0;
    int hold_seen = 0;
    logic rand_ready = 1'b0;
    logic px_gap = 1'b0;

    lcd_frame_ctrl #(
        .H_RES      (2),
        .V_RES      (2),
        .DELAY_UNIT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .phy_data      (phy_data),
        .phy_rs        (phy_rs),
        .phy_valid     (phy_valid),
        .phy_ready     (phy_ready),
        .phy_fmark_stb (phy_fmark_stb),
        .px_data       (px_data),
        .px_valid      (px_valid),
        .px_ready      (px_ready),
        .en            (en),
        .init_done     (init_done),
        .frame_stb     (frame_stb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PHY ready driver: constant high or 50% random.
    initial begin
        phy_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) phy_ready = 1'($urandom_range(0, 1));
            else            phy_ready = 1'b1;
        end
    end

    // Pixel source fed from px_q.
    initial begin
        logic hs;
        px_valid = 1'b0;
        px_data  = 16'h0000;
        forever begin
            @(negedge clk);
            hs = px_valid && px_ready;
            @(posedge clk);
            #1;
            if (hs && px_q.size() > 0) void'(px_q.pop_front());
            if (px_q.size() > 0 && (!px_gap || ($urandom_range(0, 1) == 1))) begin
                px_valid = 1'b1;
                px_data  = px_q[0];
            end else begin
                px_valid = 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on every transfer, hold-stability check.
    initial begin
        exp_t       e;
        logic       hold;
        logic [7:0] hold_data;
        logic       hold_rs;
        logic       after_cmd;
        hold = 1'b0;
        hold_data = 8'h00;
        hold_rs = 1'b0;
        after_cmd = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hold = 1'b0;
                cyc_since = 0;
            end else begin
                if (hold) begin
                    n_cmp++;
                    assert ({phy_valid, phy_rs, phy_data} === {1'b1, hold_rs, hold_data}) else begin
                        n_err++;
                        $error("FAIL hold_stable: observed v=%b rs=%b d=%h expected v=1 rs=%b d=%h",
                               phy_valid, phy_rs, phy_data, hold_rs, hold_data);
                    end
                end
                if (phy_valid && phy_ready) begin
                    last_gap = cyc_since;
                    cyc_since = 0;
                    n_cmp++;
                    assert (exp_q.size() != 0) else begin
                        n_err++;
                        $error("FAIL unexpected_byte: observed rs=%b d=%h expected no transfer",
                               phy_rs, phy_data);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        pop_cnt++;
                        n_cmp++;
                        assert ({phy_rs, phy_data, frame_stb} === {e.rs, e.data, e.last}) else begin
                            n_err++;
                            $error("FAIL byte_stream: observed rs=%b d=%h stb=%b expected rs=%b d=%h stb=%b",
                                   phy_rs, phy_data, frame_stb, e.rs, e.data, e.last);
                        end
                    end
                    if (phy_rs && after_cmd) begin
                        first_px_cyc = cyc;
                        after_cmd = 1'b0;
                    end
                    if (!phy_rs && phy_data == 8'h2C) after_cmd = 1'b1;
                    if (frame_stb) begin
                        frames++;
                        stb_cyc = cyc;
                    end
                end else begin
                    cyc_since++;
                    n_cmp++;
                    assert (frame_stb === 1'b0) else begin
                        n_err++;
                        $error("FAIL stb_no_xfer: observed %b expected 0", frame_stb);
                    end
                end
                hold = phy_valid && !phy_ready;
                if (hold) hold_seen++;
                hold_data = phy_data;
                hold_rs = phy_rs;
            end
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic rs, input logic [7:0] d, input logic last);
        exp_t e;
        e.rs = rs;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] p0, input logic [15:0] p1,
                              input logic [15:0] p2, input logic [15:0] p3);
        logic [15:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        push_exp(1'b0, 8'h2C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b1, p[i][15:8], 1'b0);
            push_exp(1'b1, p[i][7:0], (i == 3));
            px_q.push_back(p[i]);
        end
    endtask

    task automatic fmark_pulse();
        @(posedge clk);
        #1 phy_fmark_stb = 1'b1;
        @(posedge clk);
        #1 phy_fmark_stb = 1'b0;
    endtask

    task automatic wait_empty(input int budget, input string tag);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        chk(exp_q.size(), 0, tag);
    endtask

    task automatic wait_pops(input int target, input int budget);
        for (int i = 0; i < budget && pop_cnt < target; i++) @(negedge clk);
        #1;
        chk(pop_cnt >= target, 1, "wait_pops");
    endtask

    task automatic wait_init(input string tag);
        for (int i = 0; i < 10 && !init_done; i++) @(negedge clk);
        chk(init_done, 1, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(phy_valid, 0, {tag, "_valid"});
        chk(px_ready, 0, {tag, "_px_ready"});
        chk(init_done, 0, {tag, "_init_done"});
        chk(frame_stb, 0, {tag, "_frame_stb"});
        chk(phy_data, 0, {tag, "_data"});
        chk(phy_rs, 0, {tag, "_rs"});
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        phy_fmark_stb = 1'b0;
        #12;
        check_reset_outputs("reset");

        // Init program: 0x11, delay 2*4 cycles, 0x29, end.
        push_exp(1'b0, 8'h11, 1'b0);
        push_exp(1'b0, 8'h29, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_empty(200, "init_bytes");
        chk((last_gap >= 8) && (last_gap <= 16), 1, "init_delay_gap");
        wait_init("init_done");

        // Frame 1: full speed.
        en = 1'b1;
        push_frame(16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0);
        fmark_pulse();
        wait_empty(200, "frame1");
        chk(frames, 1, "frame1_count");
        chk(stb_cyc - first_px_cyc, 7, "back_to_back");

        // Frame 2: random back-pressure and pixel gaps, same stream.
        rand_ready = 1'b1;
        px_gap = 1'b1;
        push_frame(16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0);
        fmark_pulse();
        wait_empty(2000, "frame2");
        chk(frames, 2, "frame2_count");
        chk(hold_seen > 0, 1, "stalls_seen");

        // Frame 3: fmark during pixel states, en dropped mid-frame.
        push_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        fmark_pulse();
        wait_pops(pop_cnt + 3, 2000);
        fmark_pulse();
        en = 1'b0;
        fmark_pulse();
        wait_empty(2000, "frame3");
        chk(frames, 3, "frame3_count");

        // fmark with en low in IDLE is ignored.
        fmark_pulse();
        repeat (30) @(negedge clk);
        #1;
        chk(frames, 3, "en_low_ignored");
        chk(exp_q.size(), 0, "no_extra_bytes");

        // Frame 4: reset at pixel 2, then init replays.
        rand_ready = 1'b0;
        px_gap = 1'b0;
        en = 1'b1;
        push_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        fmark_pulse();
        wait_pops(pop_cnt + 5, 200);
        chk(phy_valid, 1, "pre_reset_valid");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        px_q.delete();
        push_exp(1'b0, 8'h11, 1'b0);
        push_exp(1'b0, 8'h29, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_empty(200, "init_replay");
        wait_init("init_done_replay");

        // Frame 5 after recovery.
        push_frame(16'h5A5A, 16'hA5A5, 16'h0001, 16'h8000);
        fmark_pulse();
        wait_empty(200, "frame5");
        chk(frames, 4, "frame5_count");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_frame_ctrl.md
LCD_FRAME_CTRL -- requirements
Module: lcd_frame_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 320, meaning pixels per line.
REQ-002 SHALL have parameter V_RES, default 240, meaning lines per frame.
REQ-003 SHALL have parameter DELAY_UNIT, default 1024, meaning clk cycles per init-delay tick.
REQ-004 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge
  rst_n  in  1  asynchronous, active-low reset
  phy_data  out  8  byte to LCD PHY
  phy_rs  out  1  0 = command, 1 = data
  phy_valid  out  1  byte offered to PHY
  phy_ready  in  1  PHY accepts byte this cycle
  phy_fmark_stb  in  1  one-cycle frame-mark (tearing) strobe from PHY
  px_data  in  16  RGB565 pixel
  px_valid  in  1  pixel offered
  px_ready  out  1  pixel accepted when px_valid & px_ready
  en  in  1  enable frame refresh
  init_done  out  1  init sequence complete
  frame_stb  out  1  one-cycle pulse when the last byte of a frame transfers

Function
REQ-005 SHALL treat a PHY byte as transferred only on a cycle with phy_valid & phy_ready high.
REQ-006 SHALL hold phy_data and phy_rs stable and keep phy_valid high from assertion until transfer.
REQ-007 SHALL implement states INIT_FETCH, INIT_SEND, INIT_DELAY, IDLE, WR_CMD, PIX_HI, PIX_LO.
REQ-008 SHALL leave reset in INIT_FETCH with ROM address 0.
REQ-009 SHALL read init-ROM entries {type[1:0], byte[7:0]} with 1-cycle read latency; type 00 = command (rs=0), 01 = data (rs=1), 10 = delay, 11 = end.
REQ-010 SHALL, for type 00/01, offer the byte in INIT_SEND, increment address on transfer and return to INIT_FETCH.
REQ-011 SHALL, for type 10, wait byte*DELAY_UNIT cycles in INIT_DELAY with phy_valid low; byte 0 is a zero-length delay (1 cycle max).
REQ-012 SHALL, for type 11, set init_done high, go to IDLE; init_done stays high until reset.
REQ-013 SHALL in IDLE, when en is high and phy_fmark_stb pulses, go to WR_CMD; a strobe with en low is ignored.
REQ-014 SHALL in WR_CMD offer command 0x2C (rs=0); on transfer clear pixel counter, go to PIX_HI.
REQ-015 SHALL assert px_ready only in PIX_HI while no pixel is latched; on px handshake latch px_data.
REQ-016 SHALL send px_data[15:8] (rs=1) in PIX_HI, then px_data[7:0] (rs=1) in PIX_LO; phy_valid low while waiting for a pixel (gaps allowed).
REQ-017 SHALL increment pixel counter on each low-byte transfer; at count H_RES*V_RES-1 pulse frame_stb on that transfer cycle and go to IDLE, else PIX_HI.
REQ-018 SHALL size the pixel counter as clog2(H_RES*V_RES) bits with no wrap past the last pixel.
REQ-019 SHALL ignore phy_fmark_stb outside IDLE, and complete a started frame even if en drops mid-frame.
REQ-020 SHALL reach back-to-back peak of one byte per cycle when phy_ready and px_valid stay high (pixel latch overlaps low-byte send).

Reset
REQ-021 SHALL on rst_n low immediately force phy_valid=0, px_ready=0, init_done=0, frame_stb=0, phy_data=0x00, phy_rs=0, all counters 0.
REQ-022 SHALL, on reset asserted mid-frame or mid-init, restart the full init sequence after release.

Structure
REQ-023 SHALL place entry-type codes, opcode 0x2C and the state encoding in shared package lcd_pkg.
REQ-024 SHALL instantiate one sub-module lcd_init_rom (synchronous 10-bit-wide ROM, 1-cycle latency, contents from a hex file parameter).

Verification
REQ-025 SHALL cover: ROM {00 11, 10 02, 00 29, 11 --}, DELAY_UNIT=4, phy_ready=1 -> 0x11 rs=0, 8-cycle gap, 0x29 rs=0, init_done rises next state.
REQ-026 SHALL cover: H_RES=2,V_RES=2, pixels 0x1234,0xABCD,0x0F0F,0xF0F0 after fmark -> bytes 2C(rs0),12,34,AB,CD,0F,0F,F0,F0(rs1), frame_stb with last byte.
REQ-027 SHALL cover: phy_ready toggled randomly 50% -> phy_data/phy_rs never change while phy_valid high and not ready; byte stream unchanged.
REQ-028 SHALL cover: fmark pulses during PIX states and with en=0 in IDLE -> no extra 0x2C, exactly one frame per qualified fmark.
REQ-029 SHALL cover: rst_n low at pixel 2 of frame -> phy_valid low same cycle (async), init sequence replays from address 0 after release.
